// File: rtl/wbi2c_mem_master.sv
// Wishbone-controlled I2C memory master: byte buffer, sub-address phase,
// timeout/abort/NACK reporting, driving an external lli2cm byte engine.
module wbi2c_mem_master #(
    parameter int MEM_ADDR_BITS   = 7,
    parameter int ADDR_BYTES      = 1,
    parameter int TICKBITS        = 20,
    parameter int CLOCKS_PER_TICK = 1000,
    parameter int CONSTANT_SPEED  = 0,
    parameter int READ_ONLY       = 0,
    parameter int TIMEOUT_BITS    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [MEM_ADDR_BITS-2:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [31:0]              o_wb_data,
    output logic                     o_ll_cyc,
    output logic                     o_ll_stb,
    output logic                     o_ll_we,
    output logic [7:0]               o_ll_data,
    output logic [TICKBITS-1:0]      o_ll_speed,
    input  logic                     i_ll_ack,
    input  logic                     i_ll_stall,
    input  logic                     i_ll_err,
    input  logic [7:0]               i_ll_data,
    output logic                     o_int
);
    localparam int MAB = MEM_ADDR_BITS;
    localparam logic [TICKBITS-1:0] CPT = TICKBITS'(CLOCKS_PER_TICK);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVW, S_SUBA, S_TX, S_RESTART, S_DEVR, S_RX, S_DRAIN
    } state_t;

    state_t state, state_n;
    logic stb, stb_n, cyc, cyc_n, pend, pend_n, we, we_n;
    logic [7:0] data, data_n, tx_byte;
    logic [6:0] dev, dev_n;
    logic rd, rd_n, abyte, abyte_n;
    logic [MAB-1:0] cnt, cnt_n;
    logic [15:0] sub, sub_n;
    logic err, err_n, nack, nack_n, tmo, tmo_n;
    logic [TICKBITS-1:0] speed;
    logic [TIMEOUT_BITS-1:0] tcnt;
    logic [7:0] mem [2**MAB];
    logic [31:0] rdat;

    logic wb_req, is_buf, reg_wr, cmd_wr, busy, accept, got_ack;
    logic tmo_hit, start, store, buf_wr;
    logic [MAB-3:0] widx;

    assign wb_req  = i_wb_cyc & i_wb_stb;
    assign is_buf  = i_wb_addr[MAB-2];
    assign widx    = i_wb_addr[MAB-3:0];
    assign reg_wr  = wb_req & i_wb_we & !is_buf;
    assign cmd_wr  = reg_wr & (i_wb_addr[1:0] == 2'd0);
    assign busy    = (state != S_IDLE);
    assign accept  = stb & !i_ll_stall;
    assign got_ack = i_ll_ack & (pend | accept);
    assign tmo_hit = (stb | pend) & !i_ll_ack & (&tcnt);
    assign buf_wr  = wb_req & i_wb_we & is_buf & !busy & (READ_ONLY == 0);
    assign start   = cmd_wr & (i_wb_data[MAB-1:0] != '0)
                   & (i_wb_data[16] | (READ_ONLY == 0));

    always_comb begin
        unique case (state)
            S_DEVW:  tx_byte = {dev, 1'b0};
            S_SUBA:  tx_byte = (ADDR_BYTES == 2 && !abyte) ? sub[15:8] : sub[7:0];
            S_TX:    tx_byte = mem[sub[MAB-1:0]];
            S_DEVR:  tx_byte = {dev, 1'b1};
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        stb_n   = stb & i_ll_stall;
        pend_n  = (pend | accept) & !i_ll_ack & !i_ll_err;
        cyc_n   = cyc;
        we_n    = we;
        data_n  = data;
        dev_n   = dev;
        rd_n    = rd;
        cnt_n   = cnt;
        sub_n   = sub;
        abyte_n = abyte;
        err_n   = err;
        nack_n  = nack;
        tmo_n   = tmo;
        store   = 1'b0;
        if (reg_wr && i_wb_addr[1:0] == 2'd2 && !busy)
            sub_n = i_wb_data[15:0];
        unique case (state)
            S_IDLE: begin
                cyc_n  = 1'b0;
                stb_n  = 1'b0;
                pend_n = 1'b0;
                if (start) begin
                    dev_n   = i_wb_data[23:17];
                    rd_n    = i_wb_data[16];
                    cnt_n   = i_wb_data[MAB-1:0];
                    err_n   = 1'b0;
                    nack_n  = 1'b0;
                    tmo_n   = 1'b0;
                    abyte_n = 1'b0;
                    cyc_n   = 1'b1;
                    state_n = (ADDR_BYTES == 0 && i_wb_data[16]) ? S_DEVR : S_DEVW;
                end
            end
            S_RESTART: begin
                cyc_n   = 1'b1;
                state_n = S_DEVR;
            end
            S_DRAIN: begin
                stb_n = 1'b0;
                if (!pend_n) begin
                    cyc_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                // Issue a byte only once the previous one has been acked
                if (!stb && !pend) begin
                    stb_n  = 1'b1;
                    we_n   = (state != S_RX);
                    data_n = tx_byte;
                end
                if (got_ack) begin
                    case (state)
                        S_DEVW: begin
                            if (ADDR_BYTES == 0) state_n = S_TX;
                            else state_n = S_SUBA;
                        end
                        S_SUBA: begin
                            if (ADDR_BYTES < 2 || abyte) begin
                                if (rd) begin
                                    state_n = S_RESTART;
                                    cyc_n   = 1'b0;
                                end else begin
                                    state_n = S_TX;
                                end
                            end else begin
                                abyte_n = 1'b1;
                            end
                        end
                        S_DEVR: state_n = S_RX;
                        default: begin
                            store = (state == S_RX);
                            sub_n = sub + 16'd1;
                            cnt_n = cnt - MAB'(1);
                            if (cnt == MAB'(1)) state_n = S_DRAIN;
                        end
                    endcase
                end
            end
        endcase
        if (busy && i_ll_err) begin
            err_n   = 1'b1;
            nack_n  = 1'b1;
            stb_n   = 1'b0;
            state_n = S_DRAIN;
        end
        if (busy && cmd_wr && i_wb_data[31]) begin
            stb_n   = 1'b0;
            state_n = S_DRAIN;
        end
        if (busy && tmo_hit) begin
            err_n   = 1'b1;
            tmo_n   = 1'b1;
            stb_n   = 1'b0;
            pend_n  = 1'b0;
            cyc_n   = 1'b0;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            stb   <= 1'b0;
            cyc   <= 1'b0;
            pend  <= 1'b0;
            we    <= 1'b0;
            data  <= 8'h00;
            dev   <= 7'h00;
            rd    <= 1'b0;
            cnt   <= '0;
            sub   <= 16'h0000;
            abyte <= 1'b0;
            err   <= 1'b0;
            nack  <= 1'b0;
            tmo   <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            stb   <= stb_n;
            cyc   <= cyc_n;
            pend  <= pend_n;
            we    <= we_n;
            data  <= data_n;
            dev   <= dev_n;
            rd    <= rd_n;
            cnt   <= cnt_n;
            sub   <= sub_n;
            abyte <= abyte_n;
            err   <= err_n;
            nack  <= nack_n;
            tmo   <= tmo_n;
            if (!(stb | pend) || i_ll_ack) tcnt <= '0;
            else tcnt <= tcnt + TIMEOUT_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) speed <= CPT;
        else if (CONSTANT_SPEED != 0) speed <= CPT;
        else if (reg_wr && i_wb_addr[1:0] == 2'd1) speed <= i_wb_data[TICKBITS-1:0];
        else if (speed == '0) speed <= CPT;
    end

    // Buffer is deliberately not reset; bytes are big-endian within a word
    always_ff @(posedge i_clk) begin
        if (buf_wr) begin
            for (int k = 0; k < 4; k++)
                if (i_wb_sel[3-k]) mem[{widx, 2'(k)}] <= i_wb_data[31-8*k -: 8];
        end
        if (store) mem[sub[MAB-1:0]] <= i_ll_data;
    end

    always_comb begin
        rdat = 32'h0;
        unique case (i_wb_addr[1:0])
            2'd0: begin
                rdat[31]     = busy;
                rdat[30]     = err;
                rdat[29]     = nack;
                rdat[28]     = tmo;
                rdat[23:17]  = dev;
                rdat[16]     = rd;
                rdat[MAB-1:0] = cnt;
            end
            2'd1: rdat[TICKBITS-1:0] = speed;
            2'd2: rdat[15:0] = sub;
            default: rdat = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'h0;
        end else begin
            o_wb_ack <= wb_req;
            if (is_buf)
                o_wb_data <= {mem[{widx, 2'd0}], mem[{widx, 2'd1}],
                              mem[{widx, 2'd2}], mem[{widx, 2'd3}]};
            else
                o_wb_data <= rdat;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_ll_cyc   = cyc;
    assign o_ll_stb   = stb;
    assign o_ll_we    = we;
    assign o_ll_data  = data;
    assign o_ll_speed = speed;
    assign o_int      = !busy;
endmodule

// File: tb/tb_wbi2c_mem_master.sv
// Scoreboard bench for wbi2c_mem_master: byte-engine model plus
// decoupled monitors for I2C byte requests and Wishbone read data.
module tb_wbi2c_mem_master;
    localparam int MAB = 7;
    localparam int TB  = 20;
    localparam int CPT = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst = 1'b1;
    logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [MAB-2:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [3:0] wb_sel = 4'hf;
    logic wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic ll_cyc, ll_stb, ll_we;
    logic [7:0] ll_data;
    logic [TB-1:0] ll_speed;
    logic ll_ack = 0, ll_stall = 0, ll_err = 0;
    logic [7:0] ll_rdata = 8'h00;
    logic irq;

    wbi2c_mem_master #(
        .MEM_ADDR_BITS(MAB), .ADDR_BYTES(2), .TICKBITS(TB),
        .CLOCKS_PER_TICK(CPT), .CONSTANT_SPEED(0), .READ_ONLY(0),
        .TIMEOUT_BITS(8)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
        .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
        .o_ll_cyc(ll_cyc), .o_ll_stb(ll_stb), .o_ll_we(ll_we),
        .o_ll_data(ll_data), .o_ll_speed(ll_speed),
        .i_ll_ack(ll_ack), .i_ll_stall(ll_stall), .i_ll_err(ll_err),
        .i_ll_data(ll_rdata), .o_int(irq)
    );

    typedef struct {
        bit rd;
        logic [31:0] exp;
        logic [31:0] mask;
        string name;
    } wbx_t;

    wbx_t wbq[$];
    logic [9:0] llq[$];
    logic [7:0] rxq[$];
    int n_chk = 0, n_fail = 0;
    int ack_cnt = 0, stall_budget = 0;
    bit hold_ack = 0, err_once = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] wbyte(input logic [7:0] b);
        return {2'b01, b};
    endfunction

    localparam logic [9:0] RDB  = 10'h000;
    localparam logic [9:0] DROP = 10'h200;

    task automatic wb_wr(input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s = 4'hf);
        wbq.push_back('{rd: 1'b0, exp: 32'h0, mask: 32'h0, name: "wr"});
        wb_cyc = 1; wb_stb = 1; wb_we = 1;
        wb_addr = a; wb_wdata = d; wb_sel = s;
        @(posedge clk); #1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic wb_rd(input logic [5:0] a, input logic [31:0] e,
                         input logic [31:0] m, input string n);
        wbq.push_back('{rd: 1'b1, exp: e, mask: m, name: n});
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a;
        @(posedge clk); #1;
        wb_cyc = 0; wb_stb = 0;
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 2000 && !irq; i++) begin
            @(posedge clk); #1;
        end
        chk(n, 32'(irq), 32'd1);
    endtask

    // Byte engine model: acks one clock after acceptance
    initial begin
        bit acc_prev, acc_we;
        acc_prev = 0;
        acc_we = 0;
        forever begin
            @(negedge clk);
            ll_ack = 0; ll_err = 0; ll_stall = 0;
            if (acc_prev && !hold_ack) begin
                if (err_once) begin
                    ll_err = 1;
                    err_once = 0;
                end else begin
                    ll_ack = 1;
                    ack_cnt++;
                    if (!acc_we) ll_rdata = rxq.size() > 0 ? rxq.pop_front() : 8'h00;
                end
            end
            if (ll_stb && stall_budget > 0) begin
                ll_stall = 1;
                stall_budget--;
            end
            acc_prev = ll_stb && !ll_stall && !i_rst;
            acc_we = ll_we;
        end
    end

    initial begin
        logic prev_cyc;
        logic [9:0] e;
        prev_cyc = 0;
        forever begin
            @(negedge clk); #1;
            if (!i_rst) begin
                if (ll_stb && !ll_stall) begin
                    if (llq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL ll_byte: got unexpected byte %h required none", ll_data);
                    end else begin
                        e = llq.pop_front();
                        n_chk++;
                        if (e[9] || e[8] != ll_we || (e[8] && e[7:0] != ll_data)) begin
                            n_fail++;
                            $display("FAIL ll_byte: got we=%b data=%h required %h",
                                     ll_we, ll_data, e);
                        end
                    end
                end
                if (prev_cyc && !ll_cyc) begin
                    e = llq.size() > 0 ? llq.pop_front() : 10'h3ff;
                    chk("ll_cyc_drop", 32'(e), 32'(DROP));
                end
            end
            prev_cyc = ll_cyc;
        end
    end

    initial begin
        wbx_t x;
        forever begin
            @(negedge clk); #1;
            if (wb_ack) begin
                if (wbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_ack: got ack required none");
                end else begin
                    x = wbq.pop_front();
                    if (x.rd) chk(x.name, wb_rdata & x.mask, x.exp);
                end
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 i_rst = 0;
        chk("rst_int", 32'(irq), 32'd1);
        chk("rst_cyc", 32'({ll_cyc, ll_stb}), 32'd0);
        chk("rst_speed", 32'(ll_speed), CPT);
        wb_rd(6'h00, 32'h0, 32'hffffffff, "rst_cmd");
        wb_rd(6'h01, CPT, 32'hffffffff, "rst_spd");
        wb_rd(6'h03, 32'h0, 32'hffffffff, "reg3");

        // T1: write three bytes with one stall cycle
        wb_wr(6'h20, 32'h11223344);
        wb_wr(6'h02, 32'h0);
        llq.push_back(wbyte(8'hA0)); llq.push_back(wbyte(8'h00));
        llq.push_back(wbyte(8'h00)); llq.push_back(wbyte(8'h11));
        llq.push_back(wbyte(8'h22)); llq.push_back(wbyte(8'h33));
        llq.push_back(DROP);
        stall_budget = 1;
        wb_wr(6'h00, 32'h00A00003);
        wait_idle("t1_idle");
        chk("t1_cyc", 32'(ll_cyc), 32'd0);
        wb_rd(6'h00, 32'h00A00000, 32'hffffffff, "t1_cmd");
        wb_rd(6'h02, 32'h3, 32'hffffffff, "t1_sub");

        // T2: read two bytes with repeated start
        wb_wr(6'h02, 32'h5);
        rxq.push_back(8'hDE); rxq.push_back(8'hAD);
        llq.push_back(wbyte(8'hA0)); llq.push_back(wbyte(8'h00));
        llq.push_back(wbyte(8'h05)); llq.push_back(DROP);
        llq.push_back(wbyte(8'hA1)); llq.push_back(RDB);
        llq.push_back(RDB); llq.push_back(DROP);
        wb_wr(6'h00, 32'h00A10002);
        wait_idle("t2_idle");
        wb_rd(6'h21, 32'h00DEAD00, 32'h00FFFF00, "t2_word1");
        wb_rd(6'h02, 32'h7, 32'hffffffff, "t2_sub");
        wb_rd(6'h00, 32'h00A10000, 32'hffffffff, "t2_cmd");

        // T3: NACK on device byte
        err_once = 1;
        llq.push_back(wbyte(8'hA0)); llq.push_back(DROP);
        wb_wr(6'h00, 32'h00A00003);
        wait_idle("t3_idle");
        chk("t3_cyc", 32'(ll_cyc), 32'd0);
        wb_rd(6'h00, 32'h60A00003, 32'hffffffff, "t3_cmd");

        // T4: abort after second data ack
        wb_wr(6'h22, 32'h55667788);
        wb_wr(6'h02, 32'h8);
        llq.push_back(wbyte(8'hA0)); llq.push_back(wbyte(8'h00));
        llq.push_back(wbyte(8'h08)); llq.push_back(wbyte(8'h55));
        llq.push_back(wbyte(8'h66)); llq.push_back(DROP);
        base = ack_cnt;
        wb_wr(6'h00, 32'h00A00004);
        for (int i = 0; i < 500 && ack_cnt < base + 5; i++) begin
            @(posedge clk); #1;
        end
        chk("t4_acks", 32'(ack_cnt - base), 32'd5);
        wb_wr(6'h00, 32'h80000000);
        wait_idle("t4_idle");
        wb_rd(6'h00, 32'h00A00002, 32'hffffffff, "t4_cmd");

        // T5: byte enables, 16-bit sub-address MSB first, index wrap
        wb_wr(6'h3F, 32'hAABBCCDD);
        wb_wr(6'h3F, 32'h123456EE, 4'b0001);
        wb_rd(6'h3F, 32'hAABBCCEE, 32'hffffffff, "t5_sel");
        wb_wr(6'h02, 32'h127F);
        llq.push_back(wbyte(8'hA0)); llq.push_back(wbyte(8'h12));
        llq.push_back(wbyte(8'h7F)); llq.push_back(wbyte(8'hEE));
        llq.push_back(wbyte(8'h11)); llq.push_back(DROP);
        wb_wr(6'h00, 32'h00A00002);
        wait_idle("t5_idle");
        wb_rd(6'h02, 32'h1281, 32'hffffffff, "t5_sub");
        wb_rd(6'h00, 32'h00A00000, 32'hffffffff, "t5_cmd");

        // Zero count is ignored
        wb_wr(6'h00, 32'h00A00000);
        chk("cnt0_int", 32'(irq), 32'd1);

        // T6: speed register and timeout
        wb_wr(6'h01, 32'h1234);
        wb_rd(6'h01, 32'h1234, 32'hffffffff, "t6_spd");
        chk("t6_speed_out", 32'(ll_speed), 32'h1234);
        wb_wr(6'h01, 32'h0);
        @(posedge clk); #1;
        wb_rd(6'h01, CPT, 32'hffffffff, "t6_spd0");
        hold_ack = 1;
        llq.push_back(wbyte(8'hA0)); llq.push_back(DROP);
        wb_wr(6'h00, 32'h00A00001);
        wb_wr(6'h20, 32'hFFFFFFFF);
        wait_idle("t6_idle");
        hold_ack = 0;
        wb_rd(6'h00, 32'h50A00001, 32'hffffffff, "t6_cmd");
        wb_rd(6'h20, 32'h11223344, 32'hffffffff, "t6_busy_wr");

        repeat (5) @(posedge clk);
        #1;
        chk("llq_empty", 32'(llq.size()), 32'd0);
        chk("wbq_empty", 32'(wbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
